// File: rtl/lat_tester_pkg.sv
// Shared types and defaults for the latency-test sequencer.
// The optional sensor debounce is enabled by defining LT_DEBOUNCE_EN.
package lat_tester_pkg;

    localparam int unsigned LT_CNT_W = 24;
    localparam logic [LT_CNT_W-1:0] LT_TIMEOUT_CYC = 24'd13500000;
    localparam logic [7:0] LT_DEBOUNCE_CYC = 8'd16;

    typedef enum logic [1:0] {
        LT_POS_NONE        = 2'd0,
        LT_POS_TOPLEFT     = 2'd1,
        LT_POS_CENTER      = 2'd2,
        LT_POS_BOTTOMRIGHT = 2'd3
    } lt_pos_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRECHECK = 2'd1,
        MEASURE  = 2'd2
    } lt_state_e;

endpackage

// File: rtl/lt_sensor_cond.sv
// Light-sensor conditioning: 2-FF synchronizer, registered edge detect and,
// with LT_DEBOUNCE_EN defined, a stable-high qualifier on the detect pulse.
module lt_sensor_cond
    import lat_tester_pkg::*;
(
    input  logic clk27,
    input  logic reset,
    input  logic sensor_in,
    output logic sensor_s,
    output logic detect,
    output logic capture
);

    logic sync1;
    logic sensor_q;

`ifdef LT_DEBOUNCE_EN
    logic [7:0] run_cnt;
`endif

    always_ff @(posedge clk27) begin
        if (reset) begin
            sync1    <= 1'b0;
            sensor_s <= 1'b0;
            sensor_q <= 1'b0;
            detect   <= 1'b0;
            capture  <= 1'b0;
`ifdef LT_DEBOUNCE_EN
            run_cnt  <= 8'd0;
`endif
        end else begin
            sync1    <= sensor_in;
            sensor_s <= sync1;
            sensor_q <= sensor_s;
            // Strobe marks the first high cycle so the caller can snapshot its counter
            capture  <= sensor_s & ~sensor_q;
`ifdef LT_DEBOUNCE_EN
            if (sensor_s) begin
                if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
            end else begin
                run_cnt <= 8'd0;
            end
            // Fires once, on the DEBOUNCE_CYC-th consecutive high cycle
            detect <= sensor_s && (run_cnt == (LT_DEBOUNCE_CYC - 8'd1));
`else
            detect <= sensor_s & ~sensor_q;
`endif
        end
    end

endmodule

// File: rtl/lt_sequencer.sv
// Latency-test run controller: arms on a dark frame boundary, then counts clk27
// cycles until the light sensor fires. Optional debounce via LT_DEBOUNCE_EN.
module lt_sequencer
    import lat_tester_pkg::*;
#(
    parameter int unsigned         CNT_W       = LT_CNT_W,
    parameter logic [CNT_W-1:0]    TIMEOUT_CYC = CNT_W'(LT_TIMEOUT_CYC)
) (
    input  logic             clk27,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode_in,
    input  logic             vsync_in,
    input  logic             sensor_in,
    output logic             lt_active,
    output logic [1:0]       lt_mode,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             timeout,
    output logic             busy
);

    lt_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cap_cnt;
    logic             vsync_d;
    logic             vs_fall;
    logic             sensor_s;
    logic             detect;
    logic             capture;
    logic             at_limit;

    lt_sensor_cond u_sensor_cond (
        .clk27     (clk27),
        .reset     (reset),
        .sensor_in (sensor_in),
        .sensor_s  (sensor_s),
        .detect    (detect),
        .capture   (capture)
    );

    assign vs_fall  = vsync_d & ~vsync_in;
    assign at_limit = (cnt == (TIMEOUT_CYC - CNT_W'(1)));

    always_ff @(posedge clk27) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_cnt      <= '0;
            vsync_d      <= 1'b1;
            lt_active    <= 1'b0;
            lt_mode      <= LT_POS_NONE;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vsync_d <= vsync_in;
            if (capture) cap_cnt <= cnt;

            case (state)
                IDLE: begin
                    if (start) begin
                        lt_mode      <= mode_in;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        state        <= PRECHECK;
                    end
                end

                PRECHECK: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        lt_active    <= 1'b0;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end else if (vs_fall && !sensor_s) begin
                        cnt       <= '0;
                        lt_active <= 1'b1;
                        state     <= MEASURE;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                MEASURE: begin
                    if (abort) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        lt_active    <= 1'b0;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                    end else if (detect) begin
                        // Without debounce the strobe coincides with detect
                        result       <= capture ? cnt : cap_cnt;
                        result_valid <= 1'b1;
                        lt_active    <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (at_limit) begin
                        timeout      <= 1'b1;
                        result_valid <= 1'b0;
                        lt_active    <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    lt_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lt_sequencer.sv
// Self-checking bench for lt_sequencer with a scoreboard of expected run outcomes.
module tb_lt_sequencer;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned T_CYC = 1500;
`ifdef LT_DEBOUNCE_EN
    localparam int unsigned LAG       = 15;
    localparam int unsigned GLITCH_RES = 503;
`else
    localparam int unsigned LAG       = 0;
    localparam int unsigned GLITCH_RES = 203;
`endif

    typedef struct {
        logic [CNT_W-1:0] res;
        logic             valid;
        logic             to;
    } exp_t;

    logic             clk27 = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       mode_in = 2'b00;
    logic             vsync_in = 1'b1;
    logic             sensor_in = 1'b0;
    logic             lt_active;
    logic [1:0]       lt_mode;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             timeout;
    logic             busy;

    int   checks = 0;
    int   errors = 0;
    int   act_total = 0;
    exp_t exp_q[$];

    lt_sequencer #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (CNT_W'(T_CYC))
    ) dut (
        .clk27        (clk27),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode_in      (mode_in),
        .vsync_in     (vsync_in),
        .sensor_in    (sensor_in),
        .lt_active    (lt_active),
        .lt_mode      (lt_mode),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk27 = ~clk27;

    always @(negedge clk27) if (lt_active === 1'b1) act_total++;

    task automatic step();
        @(posedge clk27);
        #1;
    endtask

    task automatic vs_edge();
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
    endtask

    task automatic do_start(input logic [1:0] m);
        mode_in = m;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (lt_active !== 1'b0) begin errors++; $display("FAIL reset_lt_active: got %b expected 0", lt_active); end
        checks++; if (lt_mode !== 2'b00) begin errors++; $display("FAIL reset_lt_mode: got %b expected 00", lt_mode); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_measure();
        bit   ok;
        exp_t e;
        int   act0;
        do_start(2'b10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL meas_busy_after_start: got %b expected 1", busy); end
        checks++; if (lt_mode !== 2'b10) begin errors++; $display("FAIL meas_lt_mode_latch: got %b expected 10", lt_mode); end
        repeat (5) step();
        checks++; if (lt_active !== 1'b0) begin errors++; $display("FAIL meas_active_precheck: got %b expected 0", lt_active); end
        act0 = act_total;
        vs_edge();
        checks++; if (lt_active !== 1'b1) begin errors++; $display("FAIL meas_active_entry: got %b expected 1", lt_active); end
        exp_q.push_back('{res: CNT_W'(1003), valid: 1'b1, to: 1'b0});
        repeat (1000) step();
        sensor_in = 1'b1;
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL meas_end_wait: busy got %b expected 0 within bound", busy); end
        e = exp_q.pop_front();
        checks++; if (result !== e.res) begin errors++; $display("FAIL meas_result: got %0d expected %0d", result, e.res); end
        checks++; if (result_valid !== e.valid) begin errors++; $display("FAIL meas_result_valid: got %b expected %b", result_valid, e.valid); end
        checks++; if (timeout !== e.to) begin errors++; $display("FAIL meas_timeout: got %b expected %b", timeout, e.to); end
        checks++; if (lt_mode !== 2'b10) begin errors++; $display("FAIL meas_lt_mode_hold: got %b expected 10", lt_mode); end
        checks++; if (act_total - act0 != 1004 + LAG) begin errors++; $display("FAIL meas_active_len: got %0d expected %0d", act_total - act0, 1004 + LAG); end
        sensor_in = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_dark_precheck();
        bit   ok;
        exp_t e;
        sensor_in = 1'b1;
        repeat (4) step();
        do_start(2'b01);
        for (int f = 0; f < 3; f++) begin
            repeat (100) step();
            vs_edge();
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dark_busy_frame%0d: got %b expected 1", f, busy); end
            checks++; if (lt_active !== 1'b0) begin errors++; $display("FAIL dark_active_frame%0d: got %b expected 0", f, lt_active); end
        end
        sensor_in = 1'b0;
        repeat (100) step();
        vs_edge();
        checks++; if (lt_active !== 1'b1) begin errors++; $display("FAIL dark_active_4th: got %b expected 1", lt_active); end
        exp_q.push_back('{res: CNT_W'(203), valid: 1'b1, to: 1'b0});
        repeat (200) step();
        sensor_in = 1'b1;
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dark_end_wait: busy got %b expected 0 within bound", busy); end
        e = exp_q.pop_front();
        checks++; if (result !== e.res) begin errors++; $display("FAIL dark_result: got %0d expected %0d", result, e.res); end
        checks++; if (result_valid !== e.valid) begin errors++; $display("FAIL dark_result_valid: got %b expected %b", result_valid, e.valid); end
        sensor_in = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_abort_timeout();
        exp_t e;
        // start coinciding with a frame edge must not use that edge
        mode_in  = 2'b11;
        start    = 1'b1;
        vsync_in = 1'b0;
        step();
        start    = 1'b0;
        vsync_in = 1'b1;
        repeat (10) step();
        checks++; if (lt_active !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL start_vsync_same_cycle: active/busy got %b%b expected 01", lt_active, busy); end
        vs_edge();
        repeat (50) step();
        abort   = 1'b1;
        start   = 1'b1;
        mode_in = 2'b00;
        step();
        abort   = 1'b0;
        start   = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (lt_active !== 1'b0) begin errors++; $display("FAIL abort_active: got %b expected 0", lt_active); end
        checks++; if (result_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL abort_flags: valid/timeout got %b%b expected 00", result_valid, timeout); end
        checks++; if (lt_mode !== 2'b11) begin errors++; $display("FAIL abort_start_ignored: lt_mode got %b expected 11", lt_mode); end
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: busy got %b expected 0", busy); end
        do_start(2'b01);
        checks++; if (busy !== 1'b1 || lt_mode !== 2'b01) begin errors++; $display("FAIL restart: busy/mode got %b/%b expected 1/01", busy, lt_mode); end
        vs_edge();
        exp_q.push_back('{res: '0, valid: 1'b0, to: 1'b1});
        repeat (T_CYC - 1) step();
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_early: timeout/busy got %b%b expected 01", timeout, busy); end
        step();
        e = exp_q.pop_front();
        checks++; if (timeout !== e.to) begin errors++; $display("FAIL timeout_flag: got %b expected %b", timeout, e.to); end
        checks++; if (result_valid !== e.valid) begin errors++; $display("FAIL timeout_valid: got %b expected %b", result_valid, e.valid); end
        checks++; if (lt_active !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: active/busy got %b%b expected 00", lt_active, busy); end
    endtask

    task automatic test_busy_start_reset();
        do_start(2'b10);
        vs_edge();
        repeat (20) step();
        mode_in = 2'b01;
        start   = 1'b1;
        step();
        start   = 1'b0;
        checks++; if (lt_mode !== 2'b10 || busy !== 1'b1 || lt_active !== 1'b1) begin errors++; $display("FAIL busy_start_ignored: mode/busy/active got %b/%b/%b expected 10/1/1", lt_mode, busy, lt_active); end
        reset = 1'b1;
        step();
        checks++; if (lt_active !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_ctl: active/busy got %b%b expected 00", lt_active, busy); end
        checks++; if (lt_mode !== 2'b00 || result !== '0) begin errors++; $display("FAIL midrun_reset_data: mode/result got %b/%0d expected 00/0", lt_mode, result); end
        checks++; if (result_valid !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL midrun_reset_flags: valid/timeout got %b%b expected 00", result_valid, timeout); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_glitch();
        bit   ok;
        exp_t e;
        do_start(2'b11);
        step();
        vs_edge();
        exp_q.push_back('{res: CNT_W'(GLITCH_RES), valid: 1'b1, to: 1'b0});
        repeat (200) step();
        sensor_in = 1'b1;
        repeat (10) step();
        sensor_in = 1'b0;
        repeat (290) step();
        sensor_in = 1'b1;
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL glitch_end_wait: busy got %b expected 0 within bound", busy); end
        e = exp_q.pop_front();
        checks++; if (result !== e.res) begin errors++; $display("FAIL glitch_result: got %0d expected %0d", result, e.res); end
        checks++; if (result_valid !== e.valid || timeout !== e.to) begin errors++; $display("FAIL glitch_flags: valid/timeout got %b%b expected %b%b", result_valid, timeout, e.valid, e.to); end
        sensor_in = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_measure();
        test_dark_precheck();
        test_abort_timeout();
        test_busy_start_reset();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
